// File: rtl/mmio_io_responder_if.sv
// Data-bus signals between the processor (master) and the board I/O responder (slave).
interface mmio_io_responder_if #(
    parameter int DBITS = 32
);
    logic [DBITS-1:0] addr;
    logic             wrEn;
    logic [DBITS-1:0] wrData;
    logic [DBITS-1:0] rdData;
    logic             sel;

    modport master (output addr, output wrEn, output wrData, input rdData, input sel);
    modport slave  (input addr, input wrEn, input wrData, output rdData, output sel);
endinterface

// File: rtl/mmio_io_responder.sv
// Memory-mapped board I/O window: HEX/LEDR/LEDG output registers, debounced KEY/SW
// inputs and a sticky key-press edge register with write-1-to-clear.
module mmio_io_deb_bit #(
    parameter int DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw_i,
    output logic deb_o,
    output logic rise_o
);
    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          deb_q, deb_d;

    always_comb begin
        cnt_d = '0;
        deb_d = deb_q;
        if (sync_q[1] != deb_q) begin
            if (cnt_q == CW'(DEB_CYCLES - 1)) deb_d = sync_q[1];
            else                              cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            cnt_q  <= '0;
            deb_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], raw_i};
            cnt_q  <= cnt_d;
            deb_q  <= deb_d;
        end
    end

    assign deb_o  = deb_q;
    // Fires in the same cycle the debounced bit is about to rise, so edge and state update together.
    assign rise_o = deb_d & ~deb_q;
endmodule

module mmio_io_responder #(
    parameter int               DBITS        = 32,
    parameter logic [DBITS-1:0] ADDR_HEX     = DBITS'(32'hF000_0000),
    parameter logic [DBITS-1:0] ADDR_LEDR    = DBITS'(32'hF000_0004),
    parameter logic [DBITS-1:0] ADDR_LEDG    = DBITS'(32'hF000_0008),
    parameter logic [DBITS-1:0] ADDR_KEY     = DBITS'(32'hF000_0010),
    parameter logic [DBITS-1:0] ADDR_SW      = DBITS'(32'hF000_0014),
    parameter logic [DBITS-1:0] ADDR_KEYEDGE = DBITS'(32'hF000_0018),
    parameter int               DEB_CYCLES   = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    mmio_io_responder_if.slave   bus,
    input  logic [9:0]           SW,
    input  logic [3:0]           KEY,
    output logic [9:0]           LEDR,
    output logic [7:0]           LEDG,
    output logic [6:0]           HEX0,
    output logic [6:0]           HEX1,
    output logic [6:0]           HEX2,
    output logic [6:0]           HEX3
);
    localparam int NUM_LANES = 14;

    logic [NUM_LANES-1:0] raw, deb, rise;
    logic [15:0] hex_q, hex_d;
    logic [9:0]  ledr_q, ledr_d;
    logic [7:0]  ledg_q, ledg_d;
    logic [3:0]  edge_q, edge_d;
    logic        hit_hex, hit_ledr, hit_ledg, hit_key, hit_sw, hit_edge;
    logic        unused_wrdata;

    // Lanes 0..9 are switches, 10..13 are keys inverted to 1 = pressed.
    assign raw = {~KEY, SW};

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_deb
        mmio_io_deb_bit #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk    (clk),
            .reset_n(reset_n),
            .raw_i  (raw[i]),
            .deb_o  (deb[i]),
            .rise_o (rise[i])
        );
    end

    assign hit_hex  = (bus.addr == ADDR_HEX);
    assign hit_ledr = (bus.addr == ADDR_LEDR);
    assign hit_ledg = (bus.addr == ADDR_LEDG);
    assign hit_key  = (bus.addr == ADDR_KEY);
    assign hit_sw   = (bus.addr == ADDR_SW);
    assign hit_edge = (bus.addr == ADDR_KEYEDGE);
    assign unused_wrdata = ^bus.wrData[DBITS-1:16];

    always_comb begin
        hex_d  = hex_q;
        ledr_d = ledr_q;
        ledg_d = ledg_q;
        edge_d = edge_q;
        if (bus.wrEn && hit_hex)  hex_d  = bus.wrData[15:0];
        if (bus.wrEn && hit_ledr) ledr_d = bus.wrData[9:0];
        if (bus.wrEn && hit_ledg) ledg_d = bus.wrData[7:0];
        if (bus.wrEn && hit_edge) edge_d = edge_q & ~bus.wrData[3:0];
        // A new press outranks a simultaneous clear of the same bit.
        edge_d = edge_d | rise[13:10];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hex_q  <= '0;
            ledr_q <= '0;
            ledg_q <= '0;
            edge_q <= '0;
        end else begin
            hex_q  <= hex_d;
            ledr_q <= ledr_d;
            ledg_q <= ledg_d;
            edge_q <= edge_d;
        end
    end

    always_comb begin
        bus.sel    = hit_hex | hit_ledr | hit_ledg | hit_key | hit_sw | hit_edge;
        bus.rdData = '0;
        if (hit_hex)  bus.rdData = DBITS'(hex_q);
        if (hit_ledr) bus.rdData = DBITS'(ledr_q);
        if (hit_ledg) bus.rdData = DBITS'(ledg_q);
        if (hit_key)  bus.rdData = DBITS'(deb[13:10]);
        if (hit_sw)   bus.rdData = DBITS'(deb[9:0]);
        if (hit_edge) bus.rdData = DBITS'(edge_q);
    end

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: seg7 = 7'b1000000;
            4'h1: seg7 = 7'b1111001;
            4'h2: seg7 = 7'b0100100;
            4'h3: seg7 = 7'b0110000;
            4'h4: seg7 = 7'b0011001;
            4'h5: seg7 = 7'b0010010;
            4'h6: seg7 = 7'b0000010;
            4'h7: seg7 = 7'b1111000;
            4'h8: seg7 = 7'b0000000;
            4'h9: seg7 = 7'b0010000;
            4'hA: seg7 = 7'b0001000;
            4'hB: seg7 = 7'b0000011;
            4'hC: seg7 = 7'b1000110;
            4'hD: seg7 = 7'b0100001;
            4'hE: seg7 = 7'b0000110;
            default: seg7 = 7'b0001110;
        endcase
    endfunction

    assign HEX0 = seg7(hex_q[3:0]);
    assign HEX1 = seg7(hex_q[7:4]);
    assign HEX2 = seg7(hex_q[11:8]);
    assign HEX3 = seg7(hex_q[15:12]);
    assign LEDR = ledr_q;
    assign LEDG = ledg_q;
endmodule

// File: tb/tb_mmio_io_responder.sv
// Scoreboard bench for the board I/O responder: expected read data is queued as stimulus is applied.
module tb_mmio_io_responder;
    localparam logic [31:0] A_HEX  = 32'hF000_0000;
    localparam logic [31:0] A_LEDR = 32'hF000_0004;
    localparam logic [31:0] A_LEDG = 32'hF000_0008;
    localparam logic [31:0] A_KEY  = 32'hF000_0010;
    localparam logic [31:0] A_SW   = 32'hF000_0014;
    localparam logic [31:0] A_EDGE = 32'hF000_0018;
    localparam logic [6:0]  G_0 = 7'b1000000, G_B = 7'b0000011, G_E = 7'b0000110, G_F = 7'b0001110;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [9:0] SW = '0;
    logic [3:0] KEY = 4'hF;
    logic [9:0] LEDR;
    logic [7:0] LEDG;
    logic [6:0] HEX0, HEX1, HEX2, HEX3;

    mmio_io_responder_if #(.DBITS(32)) bus();

    mmio_io_responder dut (
        .clk(clk), .reset_n(reset_n), .bus(bus), .SW(SW), .KEY(KEY),
        .LEDR(LEDR), .LEDG(LEDG), .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];
    logic [31:0] got, exp;

    task automatic rd(input logic [31:0] a, output logic [31:0] v);
        bus.addr = a;
        #1 v = bus.rdData;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.addr = a; bus.wrData = d; bus.wrEn = 1'b1;
        @(posedge clk); #1;
        bus.wrEn = 1'b0; bus.wrData = '0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        bus.addr = '0; bus.wrEn = 1'b0; bus.wrData = '0;
        reset_n = 1'b0;
        cycles(3);
        reset_n = 1'b1;
        cycles(2);
        n_tests++; if (LEDR !== 10'h0) begin n_fail++; $display("FAIL reset_ledr got=%h exp=%h", LEDR, 10'h0); end
        n_tests++; if (LEDG !== 8'h0) begin n_fail++; $display("FAIL reset_ledg got=%h exp=%h", LEDG, 8'h0); end
        n_tests++; if ({HEX3, HEX2, HEX1, HEX0} !== {4{G_0}})
            begin n_fail++; $display("FAIL reset_hex got=%h exp=%h", {HEX3, HEX2, HEX1, HEX0}, {4{G_0}}); end
        exp_q.push_back(32'h0);
        rd(A_KEY, got); exp = exp_q.pop_front();
        n_tests++; if (got !== exp) begin n_fail++; $display("FAIL reset_key_rd got=%h exp=%h", got, exp); end
        n_tests++; if (bus.sel !== 1'b1) begin n_fail++; $display("FAIL reset_key_sel got=%b exp=1", bus.sel); end
    endtask

    task automatic test_bus_rw;
        cycles(1);
        bus.addr = A_HEX; bus.wrData = 32'h0000_BEEF; bus.wrEn = 1'b1;
        exp_q.push_back(32'h0);
        #1 got = bus.rdData; exp = exp_q.pop_front();
        n_tests++; if (got !== exp) begin n_fail++; $display("FAIL rd_during_wr got=%h exp=%h", got, exp); end
        @(posedge clk); #1;
        bus.wrEn = 1'b0;
        exp_q.push_back(32'h0000_BEEF);
        rd(A_HEX, got); exp = exp_q.pop_front();
        n_tests++; if (got !== exp) begin n_fail++; $display("FAIL hex_rd got=%h exp=%h", got, exp); end
        n_tests++; if ({HEX3, HEX2, HEX1, HEX0} !== {G_B, G_E, G_E, G_F})
            begin n_fail++; $display("FAIL hex_glyphs got=%h exp=%h", {HEX3, HEX2, HEX1, HEX0}, {G_B, G_E, G_E, G_F}); end
        wr(A_LEDG, 32'hFFFF_FFFF);
        n_tests++; if (LEDG !== 8'hFF) begin n_fail++; $display("FAIL ledg_port got=%h exp=%h", LEDG, 8'hFF); end
        exp_q.push_back(32'h0000_00FF);
        rd(A_LEDG, got); exp = exp_q.pop_front();
        n_tests++; if (got !== exp) begin n_fail++; $display("FAIL ledg_rd got=%h exp=%h", got, exp); end
        wr(A_KEY, 32'hFFFF_FFFF);
        wr(A_SW, 32'hFFFF_FFFF);
        exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        rd(A_KEY, got); exp = exp_q.pop_front();
        n_tests++; if (got !== exp) begin n_fail++; $display("FAIL key_ro got=%h exp=%h", got, exp); end
        rd(A_SW, got); exp = exp_q.pop_front();
        n_tests++; if (got !== exp) begin n_fail++; $display("FAIL sw_ro got=%h exp=%h", got, exp); end
    endtask

    task automatic test_sw_debounce;
        cycles(1);
        SW = 10'h2A5;
        for (int k = 1; k <= 18; k++) exp_q.push_back(k >= 18 ? 32'h2A5 : 32'h0);
        for (int k = 1; k <= 18; k++) begin
            cycles(1);
            rd(A_SW, got); exp = exp_q.pop_front();
            n_tests++; if (got !== exp) begin n_fail++; $display("FAIL sw_deb_c%0d got=%h exp=%h", k, got, exp); end
        end
        for (int k = 0; k < 30; k++) begin
            if (k == 0)  SW = 10'h2A4;
            if (k == 10) SW = 10'h2A5;
            exp_q.push_back(32'h2A5);
            cycles(1);
            rd(A_SW, got); exp = exp_q.pop_front();
            n_tests++; if (got !== exp) begin n_fail++; $display("FAIL sw_glitch_c%0d got=%h exp=%h", k, got, exp); end
        end
    endtask

    task automatic test_key_edge;
        cycles(1);
        KEY = 4'b1011;
        cycles(40);
        exp_q.push_back(32'h4); exp_q.push_back(32'h4);
        rd(A_KEY, got); exp = exp_q.pop_front();
        n_tests++; if (got !== exp) begin n_fail++; $display("FAIL key_pressed got=%h exp=%h", got, exp); end
        rd(A_EDGE, got); exp = exp_q.pop_front();
        n_tests++; if (got !== exp) begin n_fail++; $display("FAIL edge_set got=%h exp=%h", got, exp); end
        KEY = 4'hF;
        cycles(25);
        exp_q.push_back(32'h0); exp_q.push_back(32'h4);
        rd(A_KEY, got); exp = exp_q.pop_front();
        n_tests++; if (got !== exp) begin n_fail++; $display("FAIL key_released got=%h exp=%h", got, exp); end
        rd(A_EDGE, got); exp = exp_q.pop_front();
        n_tests++; if (got !== exp) begin n_fail++; $display("FAIL edge_sticky got=%h exp=%h", got, exp); end
        wr(A_EDGE, 32'h4);
        exp_q.push_back(32'h0);
        rd(A_EDGE, got); exp = exp_q.pop_front();
        n_tests++; if (got !== exp) begin n_fail++; $display("FAIL edge_w1c got=%h exp=%h", got, exp); end
    endtask

    task automatic test_edge_set_vs_clear;
        cycles(1);
        KEY = 4'b1101;
        cycles(17);
        bus.addr = A_EDGE; bus.wrData = 32'h2; bus.wrEn = 1'b1;
        exp_q.push_back(32'h0);
        #1 got = bus.rdData; exp = exp_q.pop_front();
        n_tests++; if (got !== exp) begin n_fail++; $display("FAIL race_pre got=%h exp=%h", got, exp); end
        @(posedge clk); #1;
        bus.wrEn = 1'b0; bus.wrData = '0;
        exp_q.push_back(32'h2); exp_q.push_back(32'h2);
        rd(A_EDGE, got); exp = exp_q.pop_front();
        n_tests++; if (got !== exp) begin n_fail++; $display("FAIL race_set_wins got=%h exp=%h", got, exp); end
        rd(A_KEY, got); exp = exp_q.pop_front();
        n_tests++; if (got !== exp) begin n_fail++; $display("FAIL race_key got=%h exp=%h", got, exp); end
        KEY = 4'hF;
        cycles(25);
        wr(A_EDGE, 32'hF);
    endtask

    task automatic test_unmatched_and_reset;
        wr(A_LEDR, 32'h123);
        wr(A_LEDG, 32'h5A);
        bus.addr = 32'hF000_000C; bus.wrData = 32'hFFFF_FFFF; bus.wrEn = 1'b1;
        #1;
        n_tests++; if (bus.sel !== 1'b0) begin n_fail++; $display("FAIL nomatch_sel got=%b exp=0", bus.sel); end
        n_tests++; if (bus.rdData !== 32'h0) begin n_fail++; $display("FAIL nomatch_rd got=%h exp=0", bus.rdData); end
        @(posedge clk); #1;
        bus.wrEn = 1'b0;
        n_tests++; if (LEDR !== 10'h123) begin n_fail++; $display("FAIL nomatch_ledr got=%h exp=%h", LEDR, 10'h123); end
        n_tests++; if (LEDG !== 8'h5A) begin n_fail++; $display("FAIL nomatch_ledg got=%h exp=%h", LEDG, 8'h5A); end
        exp_q.push_back(32'h0000_BEEF);
        rd(A_HEX, got); exp = exp_q.pop_front();
        n_tests++; if (got !== exp) begin n_fail++; $display("FAIL nomatch_hex got=%h exp=%h", got, exp); end
        bus.addr = 32'hF000_0001;
        #1;
        n_tests++; if (bus.sel !== 1'b0) begin n_fail++; $display("FAIL misaligned_sel got=%b exp=0", bus.sel); end
        @(posedge clk); #3;
        reset_n = 1'b0;
        #1;
        n_tests++; if (LEDR !== 10'h0) begin n_fail++; $display("FAIL async_rst_ledr got=%h exp=0", LEDR); end
        n_tests++; if (HEX0 !== G_0) begin n_fail++; $display("FAIL async_rst_hex0 got=%b exp=%b", HEX0, G_0); end
        exp_q.push_back(32'h0);
        rd(A_SW, got); exp = exp_q.pop_front();
        n_tests++; if (got !== exp) begin n_fail++; $display("FAIL async_rst_sw got=%h exp=%h", got, exp); end
        @(posedge clk); #1;
        reset_n = 1'b1;
        for (int k = 1; k <= 18; k++) exp_q.push_back(k >= 18 ? 32'h2A5 : 32'h0);
        for (int k = 1; k <= 18; k++) begin
            cycles(1);
            rd(A_SW, got); exp = exp_q.pop_front();
            if (k >= 17) begin
                n_tests++; if (got !== exp) begin n_fail++; $display("FAIL post_rst_sw_c%0d got=%h exp=%h", k, got, exp); end
            end
        end
    endtask

    initial begin
        test_reset;
        test_bus_rw;
        test_sw_debounce;
        test_key_edge;
        test_edge_set_vs_clear;
        test_unmatched_and_reset;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
